// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy flags, sticky errors and optional first-word fall-through
module sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_wfull,
    output logic                  o_afull,
    output logic                  o_rempty,
    output logic                  o_aempty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  rd_acc;
    logic                  wr_acc;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = i_rd_en && (count != CNT_ZERO);
    assign wr_acc = i_wr_en && ((count != DEPTH_CNT) || rd_acc);

    assign o_count  = count;
    assign o_wfull  = (count == DEPTH_CNT);
    assign o_rempty = (count == CNT_ZERO);
    assign o_afull  = (count >= AFULL_CNT);
    assign o_aempty = (count <= AEMPTY_CNT);

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error event wins over a clear in the same cycle.
            o_overflow  <= (o_overflow && !i_clr_err) || (i_wr_en && !wr_acc);
            o_underflow <= (o_underflow && !i_clr_err) || (i_rd_en && (count == CNT_ZERO));
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rdata  = mem[rd_ptr];
            assign o_rvalid = !o_rempty;
        end else begin : g_registered
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    o_rdata  <= '0;
                    o_rvalid <= 1'b0;
                end else begin
                    o_rvalid <= rd_acc;
                    if (rd_acc) begin
                        o_rdata <= mem[rd_ptr];
                    end
                end
            end
        end
    endgenerate

endmodule
